// File: rtl/jk_cmd_arbiter_pkg.sv
// jk_cmd_arbiter_pkg: shared FSM state and command encodings for the JK command arbiter.
// Revision 1.0
`default_nettype none

package jk_cmd_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] CMD_HOLD = 2'b00;
  localparam logic [1:0] CMD_CLR  = 2'b01;
  localparam logic [1:0] CMD_SET  = 2'b10;
  localparam logic [1:0] CMD_TGL  = 2'b11;

endpackage

`default_nettype wire

// File: rtl/jk_ff_bank.sv
// jk_ff_bank: W independent JK flip-flops with synchronous active-high reset.
// Revision 1.0
`default_nettype none

module jk_ff_bank #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] j,
  input  logic [W-1:0] k,
  output logic [W-1:0] q
);

  for (genvar b = 0; b < W; b++) begin : g_bit
    always_ff @(posedge clk) begin
      if (reset) begin
        q[b] <= 1'b0;
      end else begin
        // JK: 00 hold, 01 clear, 10 set, 11 toggle
        q[b] <= (j[b] & ~q[b]) | (~k[b] & q[b]);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/jk_cmd_arbiter.sv
// jk_cmd_arbiter: round-robin arbiter applying one requester's hold/clear/set/toggle command
// per 3-cycle transaction (IDLE, APPLY, DONE) to a shared JK register. Revision 1.0
`default_nettype none

module jk_cmd_arbiter
  import jk_cmd_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [2*NREQ-1:0] cmd,
  input  logic [W*NREQ-1:0] mask,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic [W-1:0]      q,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t        state;
  state_t        state_next;
  logic [IW-1:0] ptr;
  logic [IW-1:0] owner;
  logic [IW-1:0] pick;
  logic          pick_valid;
  logic [IW:0]   rr_sum;
  logic [IW-1:0] rr_cand;
  logic [1:0]    cmd_cap;
  logic [W-1:0]  mask_cap;
  logic [W-1:0]  j;
  logic [W-1:0]  k;

  // Scan from the farthest candidate back toward ptr so the last hit is the first in RR order.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    rr_sum     = '0;
    rr_cand    = '0;
    for (int n = NREQ - 1; n >= 0; n--) begin
      rr_sum = {1'b0, ptr} + (IW+1)'(n);
      if (rr_sum >= (IW+1)'(NREQ)) begin
        rr_sum = rr_sum - (IW+1)'(NREQ);
      end
      rr_cand = rr_sum[IW-1:0];
      if (req[rr_cand]) begin
        pick_valid = 1'b1;
        pick       = rr_cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = APPLY;
      APPLY:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      owner    <= '0;
      cmd_cap  <= CMD_HOLD;
      mask_cap <= '0;
    end else begin
      if (state == IDLE && pick_valid) begin
        owner    <= pick;
        cmd_cap  <= cmd[2*pick +: 2];
        mask_cap <= mask[W*pick +: W];
      end
      if (state == DONE) begin
        ptr <= (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
      end
    end
  end

  // J/K are only driven during APPLY so the register changes on exactly one edge.
  always_comb begin
    j = '0;
    k = '0;
    if (state == APPLY) begin
      case (cmd_cap)
        CMD_CLR: k = mask_cap;
        CMD_SET: j = mask_cap;
        CMD_TGL: begin
          j = mask_cap;
          k = mask_cap;
        end
        default: ;
      endcase
    end
  end

  jk_ff_bank #(
    .W(W)
  ) u_bank (
    .clk   (clk),
    .reset (reset),
    .j     (j),
    .k     (k),
    .q     (q)
  );

  assign busy = (state != IDLE);
  assign gnt  = busy ? (NREQ'(1) << owner) : '0;
  assign ack  = (state == DONE) ? (NREQ'(1) << owner) : '0;

endmodule

`default_nettype wire

// File: tb/tb_jk_cmd_arbiter.sv
// tb_jk_cmd_arbiter: table-driven transactions plus hand sequences, with an ack/q scoreboard.
// Revision 1.0
`default_nettype none

module tb_jk_cmd_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] cmd;
  logic [W*NREQ-1:0] mask;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      q;
  logic              busy;

  jk_cmd_arbiter #(
    .NREQ(NREQ),
    .W   (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .cmd   (cmd),
    .mask  (mask),
    .gnt   (gnt),
    .ack   (ack),
    .q     (q),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         r;
    logic [1:0] c;
    logic [7:0] m;
    logic [7:0] eq;
  } vec_t;

  typedef struct {
    logic [NREQ-1:0] ack;
    logic [W-1:0]    q;
  } sb_t;

  vec_t vecs[8];
  sb_t  sbq[$];
  sb_t  sb_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Every ack must match the oldest outstanding expected transaction.
  always @(negedge clk) begin
    if (ack !== '0) begin
      if (sbq.size() == 0) begin
        check("sb_unexpected_ack", 32'(ack), 32'd0);
      end else begin
        sb_e = sbq.pop_front();
        check("sb_ack", 32'(ack), 32'(sb_e.ack));
        check("sb_q", 32'(q), 32'(sb_e.q));
      end
    end
  end

  task automatic run_txn(input int r, input logic [1:0] c, input logic [7:0] m,
                         input logic [7:0] eq);
    sb_t e;
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << r;
    req            = oh;
    cmd[2*r +: 2]  = c;
    mask[W*r +: W] = m;
    e.ack = oh;
    e.q   = eq;
    sbq.push_back(e);
    cyc();
    check("txn_apply_gnt", 32'(gnt), 32'(oh));
    check("txn_apply_ack", 32'(ack), 32'd0);
    check("txn_apply_busy", 32'(busy), 32'd1);
    cyc();
    check("txn_done_gnt", 32'(gnt), 32'(oh));
    check("txn_done_ack", 32'(ack), 32'(oh));
    check("txn_done_q", 32'(q), 32'(eq));
    req = '0;
    cyc();
    check("txn_idle_gnt", 32'(gnt), 32'd0);
    check("txn_idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic push_exp(input logic [NREQ-1:0] a, input logic [W-1:0] v);
    sb_t e;
    e.ack = a;
    e.q   = v;
    sbq.push_back(e);
  endtask

  initial begin
    vecs[0] = '{0, 2'b10, 8'h0F, 8'h0F};
    vecs[1] = '{2, 2'b11, 8'hFF, 8'hF0};
    vecs[2] = '{2, 2'b11, 8'hFF, 8'h0F};
    vecs[3] = '{1, 2'b10, 8'hF0, 8'hFF};
    vecs[4] = '{3, 2'b00, 8'hFF, 8'hFF};
    vecs[5] = '{0, 2'b01, 8'h0F, 8'hF0};
    vecs[6] = '{3, 2'b11, 8'h0A, 8'hFA};
    vecs[7] = '{1, 2'b10, 8'h05, 8'hFF};

    req   = '0;
    cmd   = '0;
    mask  = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_q", 32'(q), 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].r, vecs[i].c, vecs[i].m, vecs[i].eq);
    end

    // Command/mask/req change during APPLY must not alter the captured clear 0x3C.
    req         = 4'b0010;
    cmd[3:2]    = 2'b01;
    mask[15:8]  = 8'h3C;
    push_exp(4'b0010, 8'hC3);
    cyc();
    check("late_apply_gnt", 32'(gnt), 32'h2);
    cmd[3:2]   = 2'b10;
    mask[15:8] = 8'h00;
    req        = '0;
    cyc();
    check("late_done_ack", 32'(ack), 32'h2);
    check("late_done_q", 32'(q), 32'hC3);
    cyc();
    check("late_idle_busy", 32'(busy), 32'd0);

    run_txn(0, 2'b11, 8'h99, 8'h5A);
    run_txn(3, 2'b00, 8'hFF, 8'h5A);

    // Round robin over all four requesters from ptr=0.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rr_rst_q", 32'(q), 32'd0);
    for (int i = 0; i < NREQ; i++) begin
      cmd[2*i +: 2]  = 2'b10;
      mask[W*i +: W] = 8'(1 << i);
    end
    push_exp(4'b0001, 8'h01);
    push_exp(4'b0010, 8'h03);
    push_exp(4'b0100, 8'h07);
    push_exp(4'b1000, 8'h0F);
    req = 4'b1111;
    for (int t = 0; t < 12; t++) begin
      cyc();
      if (t % 3 == 2) begin
        check("rr_gnt_idle", 32'(gnt), 32'd0);
      end else begin
        check("rr_gnt", 32'(gnt), 32'(1 << (t / 3)));
      end
      check("rr_ack", 32'(ack), (t % 3 == 1) ? 32'(1 << (t / 3)) : 32'd0);
    end
    req = '0;
    cyc();
    req = 4'b1111;
    push_exp(4'b0001, 8'h0F);
    cyc();
    check("rr_ptr_wrap_gnt", 32'(gnt), 32'h1);
    req = '0;
    cyc();
    check("rr_ptr_wrap_ack", 32'(ack), 32'h1);
    cyc();

    // Reset in APPLY aborts the set; first edge after reset samples req.
    req       = 4'b0001;
    cmd[1:0]  = 2'b10;
    mask[7:0] = 8'hFF;
    cyc();
    check("abort_apply_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    req   = '0;
    cyc();
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_q", 32'(q), 32'd0);
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    reset        = 1'b0;
    req          = 4'b0100;
    cmd[5:4]     = 2'b10;
    mask[23:16]  = 8'h81;
    push_exp(4'b0100, 8'h81);
    cyc();
    check("post_rst_gnt", 32'(gnt), 32'h4);
    req = '0;
    cyc();
    check("post_rst_q", 32'(q), 32'h81);
    cyc();

    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/jk_cmd_arbiter.md
JK_CMD_ARBITER -- requirements
Module: jk_cmd_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter W, default 8, width of the shared JK flip-flop register.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  NREQ  per-requester request; held high until the matching ack.
REQ-006 SHALL have port cmd  input  2*NREQ  per-requester command at cmd[2i+1:2i]: 00 hold, 01 clear, 10 set, 11 toggle.
REQ-007 SHALL have port mask  input  W*NREQ  per-requester bit mask at mask[W*i+W-1:W*i]; 1 = bit affected.
REQ-008 SHALL have port gnt  output  NREQ  one-hot grant to the owner of the current transaction.
REQ-009 SHALL have port ack  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port q  output  W  current shared register value.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, APPLY, DONE.
REQ-013 IDLE: if any req bit is high, SHALL select requester g by round-robin from pointer ptr, capture cmd and mask of g, and go to APPLY; else stay in IDLE.
REQ-014 Round-robin SHALL search indices ptr, ptr+1, ... mod NREQ and pick the first with req high.
REQ-015 APPLY: for each bit with captured mask 1, SHALL drive the bit's J/K as cmd 00 -> J=0,K=0; 01 -> 0,1; 10 -> 1,0; 11 -> 1,1; bits with mask 0 SHALL get J=K=0; always go to DONE.
REQ-016 The register SHALL update on the edge that ends APPLY, using JK semantics: hold, clear, set, toggle.
REQ-017 DONE: ack[g] SHALL be high for exactly this cycle, q SHALL already show the new value, ptr SHALL become (g+1) mod NREQ, and the FSM SHALL return to IDLE.
REQ-018 gnt[g] SHALL be high in APPLY and DONE only; gnt SHALL be all-zero in IDLE.
REQ-019 Latency SHALL be fixed: req sampled in IDLE at edge N; APPLY at N+1; DONE (ack, new q) at N+2; next grant no earlier than edge N+3.
REQ-020 cmd, mask, or req changes after capture SHALL NOT affect the transaction in flight; req dropping before ack SHALL NOT abort it.
REQ-021 With only one requester active continuously, the block SHALL serve it once every 3 cycles.
REQ-022 Simultaneous requests SHALL be served one per transaction in round-robin order; no requester SHALL wait more than NREQ-1 transactions.
REQ-023 cmd 00 with any mask SHALL complete a full transaction (gnt/ack) and leave q unchanged.

Reset
REQ-024 While reset is high at a clock edge: q=0, gnt=0, ack=0, busy=0, ptr=0, FSM=IDLE, captured cmd and mask cleared.
REQ-025 Reset asserted during APPLY or DONE SHALL abort the transaction with no ack, and the register write in APPLY SHALL NOT take effect.
REQ-026 The first edge after reset deasserts SHALL sample req normally.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE, APPLY, DONE) and the command encodings (CMD_HOLD, CMD_CLR, CMD_SET, CMD_TGL).
REQ-028 The W-bit JK register SHALL be a sub-module jk_ff_bank (ports clk, reset, j[W], k[W], q[W]), instantiated once; the arbiter drives only its j/k.

Verification (NREQ=4, W=8)
REQ-029 Reset, then req=0001, cmd0=10, mask0=0x0F -> gnt=0001 at N+1..N+2, ack=0001 at N+2, q=0x0F.
REQ-030 From q=0x0F, req=0100, cmd2=11, mask2=0xFF -> q=0xF0 at DONE; repeat -> q=0x0F.
REQ-031 req=1111 held for 12 cycles, ptr=0 -> gnt order 0,1,2,3, one ack every 3 cycles, ptr=0 after 4th DONE.
REQ-032 From q=0xFF, req=0010, cmd1=01, mask1=0x3C, and cmd1 changed to 10 during APPLY -> q=0xC3.
REQ-033 reset pulsed during APPLY of a set 0xFF transaction -> no ack, q=0x00, gnt=0, busy=0 next cycle.
REQ-034 req=1000, cmd3=00, mask3=0xFF from q=0x5A -> ack=1000 at N+2, q stays 0x5A.
